multi_ctrl_fsm: RTL and testbench
=================================

// Module: multi_ctrl_fsm
// PURPOSE
//  Main control unit for the multicycle MIPS CPU, successor to Multi_MainDec.
//  Owns the instruction-phase state register; Multi_MainDec took the state externally.
//  Adds memory wait-states (mem_ready), optional immediate-logic ops and illegal-opcode handling.
//  Adds a retired-instruction counter.
//  Sits between the IR opcode field and the datapath/ALU decoder.
// PARAMETERS
//  EXT_OPS          1   1: also decode andi(001100), ori(001101), slti(001010); 0: these are illegal
//  MEM_WAIT         1   1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready is ignored (treated as 1)
//  TRAP_ON_ILLEGAL  0   1: an illegal op parks the FSM in ILLEGAL until reset; 0: skip it and refetch
//  CNT_W            32  width of instr_count
// PORTS
//  clk          in   1      rising-edge clock
//  reset        in   1      synchronous, active-high
//  Op           in   6      IR[31:26]; stable from DECODE onward
//  mem_ready    in   1      memory completes the access this cycle
//  MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite, ZeroExt
//               out  1 each  datapath controls
//  ALUSrcB      out  2      00 reg B, 01 const 4, 10 signext imm, 11 imm<<2
//  PCSrc        out  2      00 ALU result, 01 ALUOut, 10 jump target
//  ALUOp        out  3      000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//  state_o      out  4      current state, for debug
//  instr_done   out  1      last cycle of the instruction; next state is FETCH
//  illegal_op   out  1      high while in ILLEGAL
//  instr_count  out  CNT_W  count of retired instructions
// BEHAVIOUR
//  Reset:
//   - While reset is high, every control output, instr_done and illegal_op is forced to 0.
//   - On the reset edge: state <= FETCH and instr_count <= 0.
//   - Reset wins over any transition, including mid-instruction and during a wait.
//  Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7,
//   BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11, ILLEGAL 15.
//   Unused encodings go to FETCH on the next clock, with all outputs 0.
//  Per-state outputs (all unlisted outputs are 0):
//   FETCH:   IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000.
//            IRWrite=PCWrite=rdy. Moves to DECODE when rdy.
//            rdy = mem_ready | ~MEM_WAIT.
//   DECODE:  ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by Op:
//            lw/sw -> MEMADR; R(000000) -> EXECUTE; beq(000100) -> BRANCH;
//            addi(001000) -> IMMEXEC; j(000010) -> JUMP;
//            EXT_OPS ops -> IMMEXEC; anything else -> ILLEGAL.
//   MEMADR:  ALUSrcA=1, ALUSrcB=10, ALUOp=000. lw -> MEMRD, sw -> MEMWR.
//   MEMRD:   IorD=1. Moves to MEMWB when rdy.
//   MEMWB:   RegDst=0, MemToReg=1, RegWrite=1. instr_done=1.
//   MEMWR:   IorD=1, MemWrite=1 for every cycle of the wait. instr_done=rdy.
//   EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=010.
//   ALUWB:   RegDst=1, MemToReg=0, RegWrite=1. instr_done=1.
//   BRANCH:  ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, Branch=1. instr_done=1.
//   IMMEXEC: ALUSrcA=1, ALUSrcB=10. ALUOp by Op: addi 000, andi 011, ori 100, slti 101.
//            ZeroExt=1 for andi/ori.
//   IMMWB:   RegDst=0, MemToReg=0, RegWrite=1. instr_done=1.
//   JUMP:    PCSrc=10, PCWrite=1. instr_done=1.
//   ILLEGAL: illegal_op=1; no PC or register write.
//            TRAP_ON_ILLEGAL=0: instr_done=1, then FETCH (one cycle).
//            TRAP_ON_ILLEGAL=1: stays here until reset; instr_done=0.
//  Transitions: every state with instr_done=1 goes to FETCH; other states follow the order above.
//  Latency at zero wait: beq/j 3 cycles; R/sw/addi/imm 4; lw 5.
//   Each cycle of mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
//  instr_count: +1 on every clock edge with instr_done=1 and reset=0; wraps 2^CNT_W-1 -> 0.
//   An illegal skip counts as retired.
//  Op is sampled only in DECODE and IMMEXEC; Op changes in other states have no effect.
// STRUCTURE
//  Shared package mips_ctrl_pkg:
//   - state localparams S_FETCH..S_ILLEGAL
//   - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_ANDI, OP_ORI, OP_SLTI
//   - ALUOp constants ALU_ADD..ALU_SLT
//  Single module; next-state logic, output decode and counter are separate always blocks.
//  No sub-module.
// TESTING
//  1 reset=1 for 2 clk, then Op=000000, mem_ready=1 -> outputs 0 during reset;
//    states 0,1,6,7,0; instr_done only in ALUWB; instr_count=1.
//  2 Op=100011 (lw), mem_ready low for 2 cycles in FETCH and in MEMRD -> IRWrite/PCWrite only in the
//    ready FETCH cycle; MEMRD lasts 3 cycles; 9 cycles total; RegWrite=1, MemToReg=1 in MEMWB.
//  3 sw with mem_ready=0 for 1 cycle, then beq, then j -> MemWrite high 2 cycles;
//    beq: PCSrc=01, Branch=1; j: PCSrc=10, PCWrite=1; instr_count=3.
//  4 EXT_OPS=1: ori(001101) -> IMMEXEC ALUOp=100, ZeroExt=1, IMMWB RegWrite=1.
//    EXT_OPS=0: same Op -> ILLEGAL.
//  5 Op=111111: TRAP_ON_ILLEGAL=0 -> illegal_op 1 cycle, then FETCH, count+1.
//    TRAP_ON_ILLEGAL=1 -> stays in state 15 for 20 cycles until reset, then FETCH.
//  6 CNT_W=3: retire 9 instructions -> instr_count=1.
//    reset asserted mid-MEMRD -> state 0, count 0 on the next edge.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control path: state codes, opcodes, ALU ops.
// No logic; no latency; no backpressure.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    function automatic logic is_ext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

endpackage

// File: rtl/multi_ctrl_fsm.sv
// Multicycle MIPS main control FSM with memory wait-states, illegal-op handling, retire counter.
// Latency: beq/j 3, R/sw/addi/imm 4, lw 5 cycles; controls are combinational from state.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR (when MEM_WAIT=1).
module multi_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit EXT_OPS         = 1'b1,
    parameter bit MEM_WAIT        = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b0,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic             mem_ready,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic             RegWrite,
    output logic             ZeroExt,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUOp,
    output logic [3:0]       state_o,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t           state_q, state_d;
    logic             is_sw_q;
    logic [CNT_W-1:0] count_q;
    logic             rdy;

    assign rdy         = mem_ready | ~MEM_WAIT;
    assign state_o     = state_q;
    assign instr_count = count_q;

    // lw/sw direction is captured in DECODE so MEMADR never looks at Op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) is_sw_q <= (Op == OP_SW);
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW)      state_d = S_MEMADR;
                else if (Op == OP_RTYPE)             state_d = S_EXECUTE;
                else if (Op == OP_BEQ)               state_d = S_BRANCH;
                else if (Op == OP_ADDI)              state_d = S_IMMEXEC;
                else if (Op == OP_J)                 state_d = S_JUMP;
                else if (EXT_OPS && is_ext_op(Op))   state_d = S_IMMEXEC;
                else                                 state_d = S_ILLEGAL;
            end
            S_MEMADR:  state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = rdy ? S_FETCH : S_MEMWR;
            S_EXECUTE: state_d = S_ALUWB;
            S_IMMEXEC: state_d = S_IMMWB;
            S_ILLEGAL: state_d = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        MemToReg   = 1'b0;
        RegDst     = 1'b0;
        IorD       = 1'b0;
        ALUSrcA    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        ZeroExt    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUOp      = ALU_ADD;
        instr_done = 1'b0;
        illegal_op = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB = 2'b01;
                    IRWrite = rdy;
                    PCWrite = rdy;
                end
                S_DECODE:  ALUSrcB = 2'b11;
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMRD:   IorD = 1'b1;
                S_MEMWB: begin
                    MemToReg   = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    IorD       = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = rdy;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                end
                S_ALUWB: begin
                    RegDst     = 1'b1;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 1'b1;
                    ALUOp      = ALU_SUB;
                    PCSrc      = 2'b01;
                    Branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_IMMEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    if (EXT_OPS) begin
                        case (Op)
                            OP_ANDI: ALUOp = ALU_AND;
                            OP_ORI:  ALUOp = ALU_OR;
                            OP_SLTI: ALUOp = ALU_SLT;
                            default: ALUOp = ALU_ADD;
                        endcase
                        ZeroExt = (Op == OP_ANDI) || (Op == OP_ORI);
                    end
                end
                S_IMMWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCSrc      = 2'b10;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
                S_ILLEGAL: begin
                    illegal_op = 1'b1;
                    instr_done = ~TRAP_ON_ILLEGAL;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)           count_q <= '0;
        else if (instr_done) count_q <= count_q + CNT_W'(1);
    end

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Three configurations of multi_ctrl_fsm driven by per-instruction transactions
// with random waits; expected cycles come from each instruction's phase path.
module tb_multi_ctrl_fsm;

    typedef struct packed {
        logic m2r, rdst, iord, srca, irw, memw, pcw, br, regw, zext;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic [3:0] st;
        logic done, ill;
    } outs_t;

    typedef enum int {PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW, PH_EX,
                      PH_AWB, PH_BR, PH_IE, PH_IWB, PH_J, PH_IL} ph_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_IMM = 4, K_J = 5, K_ILL = 6;

    logic        clk;
    logic        rst [3];
    logic [5:0]  op  [3];
    logic        mr  [3];
    outs_t       obs [3];
    logic [31:0] cnt_o [3];

    longint cnt_m [3];
    int     checks = 0;
    int     fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CW = (g == 0) ? 32 : 3;
        logic MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite, ZeroExt;
        logic [1:0] ALUSrcB, PCSrc;
        logic [2:0] ALUOp;
        logic [3:0] state_o;
        logic instr_done, illegal_op;
        logic [CW-1:0] instr_count;
        multi_ctrl_fsm #(
            .EXT_OPS(g == 0), .MEM_WAIT(g != 2), .TRAP_ON_ILLEGAL(g == 1), .CNT_W(CW)
        ) dut (
            .clk(clk), .reset(rst[g]), .Op(op[g]), .mem_ready(mr[g]),
            .MemToReg(MemToReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
            .IRWrite(IRWrite), .MemWrite(MemWrite), .PCWrite(PCWrite), .Branch(Branch),
            .RegWrite(RegWrite), .ZeroExt(ZeroExt), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
            .ALUOp(ALUOp), .state_o(state_o), .instr_done(instr_done),
            .illegal_op(illegal_op), .instr_count(instr_count)
        );
        assign obs[g] = {MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch,
                         RegWrite, ZeroExt, ALUSrcB, PCSrc, ALUOp, state_o, instr_done, illegal_op};
        assign cnt_o[g] = 32'(instr_count);
    end

    function automatic bit cfg_ext(int i);  return i == 0; endfunction
    function automatic bit cfg_wait(int i); return i != 2; endfunction
    function automatic bit cfg_trap(int i); return i == 1; endfunction
    function automatic longint cfg_mask(int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'h7;
    endfunction

    function automatic logic [3:0] st_code(ph_t p);
        case (p)
            PH_F:   return 4'd0;   PH_D:   return 4'd1;   PH_MA:  return 4'd2;
            PH_MR:  return 4'd3;   PH_MWB: return 4'd4;   PH_MW:  return 4'd5;
            PH_EX:  return 4'd6;   PH_AWB: return 4'd7;   PH_BR:  return 4'd8;
            PH_IE:  return 4'd9;   PH_IWB: return 4'd10;  PH_J:   return 4'd11;
            default: return 4'd15;
        endcase
    endfunction

    function automatic int classify(logic [5:0] o, int i);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_IMM;
            6'b000010: return K_J;
            6'b001100, 6'b001101, 6'b001010: return cfg_ext(i) ? K_IMM : K_ILL;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(int k);
        case (k)
            0: return 6'b000000;  1: return 6'b100011;  2: return 6'b101011;
            3: return 6'b000100;  4: return 6'b001000;  5: return 6'b000010;
            6: return 6'b001100;  7: return 6'b001101;  8: return 6'b001010;
            default: return 6'b111111;
        endcase
    endfunction

    function automatic outs_t exp_vec(ph_t p, logic [5:0] o, logic r, int i);
        outs_t e = '0;
        logic  re = r | ~cfg_wait(i);
        case (p)
            PH_F:   begin e.srcb = 2'b01; e.irw = re; e.pcw = re; end
            PH_D:   e.srcb = 2'b11;
            PH_MA:  begin e.srca = 1; e.srcb = 2'b10; end
            PH_MR:  e.iord = 1;
            PH_MWB: begin e.m2r = 1; e.regw = 1; e.done = 1; end
            PH_MW:  begin e.iord = 1; e.memw = 1; e.done = re; end
            PH_EX:  begin e.srca = 1; e.aluop = 3'b010; end
            PH_AWB: begin e.rdst = 1; e.regw = 1; e.done = 1; end
            PH_BR:  begin e.srca = 1; e.aluop = 3'b001; e.pcsrc = 2'b01; e.br = 1; e.done = 1; end
            PH_IE: begin
                e.srca = 1; e.srcb = 2'b10;
                if (o == 6'b001100) begin e.aluop = 3'b011; e.zext = 1; end
                if (o == 6'b001101) begin e.aluop = 3'b100; e.zext = 1; end
                if (o == 6'b001010) e.aluop = 3'b101;
            end
            PH_IWB: begin e.regw = 1; e.done = 1; end
            PH_J:   begin e.pcsrc = 2'b10; e.pcw = 1; e.done = 1; end
            default: begin e.ill = 1; e.done = ~cfg_trap(i); end
        endcase
        e.st = st_code(p);
        return e;
    endfunction

    task automatic chk_cnt(int i, logic [31:0] want, string tag);
        checks++;
        assert (cnt_o[i] === want) else begin
            fails++;
            $error("FAIL %s dut%0d count=%0d want=%0d", tag, i, cnt_o[i], want);
        end
    endtask

    // Reset held for n cycles; outputs other than state_o must read zero throughout.
    task automatic do_reset(int i, int n);
        outs_t z;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst[i] = 1'b1;
            op[i]  = 6'($urandom);
            mr[i]  = 1'($urandom);
            #1;
            z = obs[i];
            z.st = 4'h0;
            checks++;
            assert (z === outs_t'(0)) else begin
                fails++;
                $error("FAIL reset_outs dut%0d obs=%h want=0", i, z);
            end
        end
        cnt_m[i] = 0;
    endtask

    task automatic run_instr(int i, logic [5:0] o, int wf, int wm, int stop_after);
        ph_t  phs[$];
        logic rs[$];
        outs_t e;
        int   kind = classify(o, i);
        if (cfg_wait(i)) begin
            repeat (wf) begin phs.push_back(PH_F); rs.push_back(1'b0); end
            phs.push_back(PH_F); rs.push_back(1'b1);
        end else begin
            phs.push_back(PH_F); rs.push_back(wf == 0);
        end
        phs.push_back(PH_D); rs.push_back(1'($urandom));
        case (kind)
            K_LW, K_SW: begin
                phs.push_back(PH_MA); rs.push_back(1'($urandom));
                if (cfg_wait(i)) begin
                    repeat (wm) begin phs.push_back(kind == K_LW ? PH_MR : PH_MW); rs.push_back(1'b0); end
                    phs.push_back(kind == K_LW ? PH_MR : PH_MW); rs.push_back(1'b1);
                end else begin
                    phs.push_back(kind == K_LW ? PH_MR : PH_MW); rs.push_back(wm == 0);
                end
                if (kind == K_LW) begin phs.push_back(PH_MWB); rs.push_back(1'($urandom)); end
            end
            K_R:   begin phs.push_back(PH_EX); rs.push_back(1'b1); phs.push_back(PH_AWB); rs.push_back(1'b0); end
            K_BEQ: begin phs.push_back(PH_BR); rs.push_back(1'b0); end
            K_IMM: begin phs.push_back(PH_IE); rs.push_back(1'b1); phs.push_back(PH_IWB); rs.push_back(1'b0); end
            K_J:   begin phs.push_back(PH_J);  rs.push_back(1'b0); end
            default: repeat (cfg_trap(i) ? 20 : 1) begin phs.push_back(PH_IL); rs.push_back(1'($urandom)); end
        endcase
        for (int k = 0; k < phs.size(); k++) begin
            if (stop_after != 0 && k == stop_after) break;
            @(negedge clk);
            rst[i] = 1'b0;
            op[i]  = (phs[k] == PH_F) ? 6'($urandom) : o;
            mr[i]  = rs[k];
            #1;
            e = exp_vec(phs[k], o, rs[k], i);
            checks++;
            assert (obs[i] === e) else begin
                fails++;
                $error("FAIL step dut%0d op=%b cyc=%0d obs=%h want=%h", i, o, k, obs[i], e);
            end
            chk_cnt(i, 32'(cnt_m[i]), "count");
            if (e.done) cnt_m[i] = (cnt_m[i] + 1) & cfg_mask(i);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; op[i] = 6'b0; mr[i] = 1'b1; cnt_m[i] = 0;
        end

        // Config 0: EXT_OPS=1, MEM_WAIT=1, skip illegal, 32-bit counter.
        do_reset(0, 2);
        run_instr(0, 6'b000000, 0, 0, 0);
        run_instr(0, 6'b100011, 2, 2, 0);
        run_instr(0, 6'b101011, 0, 1, 0);
        run_instr(0, 6'b000100, 0, 0, 0);
        run_instr(0, 6'b000010, 0, 0, 0);
        run_instr(0, 6'b001101, 0, 0, 0);
        run_instr(0, 6'b111111, 1, 0, 0);
        for (int n = 0; n < 30; n++)
            run_instr(0, pick_op($urandom_range(0, 9)), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        run_instr(0, 6'b100011, 0, 2, 4);
        do_reset(0, 1);
        run_instr(0, 6'b000000, 0, 0, 0);

        // Config 1: EXT_OPS=0, trap on illegal, 3-bit counter.
        do_reset(1, 1);
        run_instr(1, 6'b001101, 0, 0, 0);
        do_reset(1, 1);
        run_instr(1, 6'b111111, 0, 0, 0);
        do_reset(1, 1);
        for (int n = 0; n < 9; n++)
            run_instr(1, pick_op($urandom_range(0, 5)), $urandom_range(0, 2), $urandom_range(0, 2), 0);
        @(negedge clk);
        mr[1] = 1'b0;
        #1;
        chk_cnt(1, 32'd1, "wrap9");
        do_reset(1, 1);

        // Config 2: EXT_OPS=0, mem_ready ignored, skip illegal, 3-bit counter.
        do_reset(2, 2);
        run_instr(2, 6'b001101, 0, 0, 0);
        run_instr(2, 6'b100011, 2, 2, 0);
        for (int n = 0; n < 20; n++)
            run_instr(2, pick_op($urandom_range(0, 9)), $urandom_range(0, 2), $urandom_range(0, 2), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
